// File: rtl/decode_pkg.sv
// decode_pkg: MIPS-I opcode/funct constants, ALU code enum and decode control bundle
package decode_pkg;

    localparam logic [5:0] OP_R      = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,  ALU_AND  = 5'd1,  ALU_XOR  = 5'd2,  ALU_OR   = 5'd3,
        ALU_NOR  = 5'd4,  ALU_SUB  = 5'd5,  ALU_ANDI = 5'd6,  ALU_XORI = 5'd7,
        ALU_ORI  = 5'd8,  ALU_JR   = 5'd9,  ALU_BEQ  = 5'd10, ALU_BNE  = 5'd11,
        ALU_BGEZ = 5'd12, ALU_BGTZ = 5'd13, ALU_BLEZ = 5'd14, ALU_BLTZ = 5'd15,
        ALU_SLL  = 5'd16, ALU_SRL  = 5'd17, ALU_SRA  = 5'd18, ALU_SLT  = 5'd19,
        ALU_SLTU = 5'd20
    } alu_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
        logic memwrite;
        logic memread;
        logic alusrca;
        logic alusrcb;
        logic regdst;
        logic j;
        logic jr;
        logic illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: ID/EX register bundle between decode (master) and execute (slave)
//   valid/ready handshake, pc, register fields, immediate, jump target, alucode, control bits
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] jtarget;
    logic [4:0]      alucode;
    logic            memtoreg;
    logic            regwrite;
    logic            memwrite;
    logic            memread;
    logic            alusrca;
    logic            alusrcb;
    logic            regdst;
    logic            j;
    logic            jr;
    logic            illegal;

    modport master (
        output valid, pc, rs, rt, rd, shamt, imm, jtarget, alucode,
               memtoreg, regwrite, memwrite, memread, alusrca, alusrcb, regdst, j, jr, illegal,
        input  ready
    );

    modport slave (
        input  valid, pc, rs, rt, rd, shamt, imm, jtarget, alucode,
               memtoreg, regwrite, memwrite, memread, alusrca, alusrcb, regdst, j, jr, illegal,
        output ready
    );
endinterface

// File: rtl/decode_ctrl.sv
// decode_ctrl: combinational MIPS-I decoder
//   instr -> ctrl (control bits incl. illegal), alucode, extended imm, uses_rs/uses_rt
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output alu_t            alucode,
    output logic [XLEN-1:0] imm,
    output logic            uses_rs,
    output logic            uses_rt
);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic r_alu, sh_imm, sh_var, is_jr, i_alu, is_lw, is_sw, is_br, is_j, sext, zext, legal;
    logic nop, kill;
    alu_t alu;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign rt = instr[20:16];

    always_comb begin
        {r_alu, sh_imm, sh_var, is_jr, i_alu, is_lw, is_sw, is_br, is_j, sext, zext} = '0;
        legal = 1'b1;
        alu   = ALU_ADD;
        case (op)
            OP_R: begin
                case (fn)
                    FN_ADD, FN_ADDU: begin r_alu = 1'b1; alu = ALU_ADD;  end
                    FN_SUB, FN_SUBU: begin r_alu = 1'b1; alu = ALU_SUB;  end
                    FN_AND:          begin r_alu = 1'b1; alu = ALU_AND;  end
                    FN_OR:           begin r_alu = 1'b1; alu = ALU_OR;   end
                    FN_XOR:          begin r_alu = 1'b1; alu = ALU_XOR;  end
                    FN_NOR:          begin r_alu = 1'b1; alu = ALU_NOR;  end
                    FN_SLT:          begin r_alu = 1'b1; alu = ALU_SLT;  end
                    FN_SLTU:         begin r_alu = 1'b1; alu = ALU_SLTU; end
                    FN_SLL:          begin sh_imm = 1'b1; alu = ALU_SLL; end
                    FN_SRL:          begin sh_imm = 1'b1; alu = ALU_SRL; end
                    FN_SRA:          begin sh_imm = 1'b1; alu = ALU_SRA; end
                    FN_SLLV:         begin sh_var = 1'b1; alu = ALU_SLL; end
                    FN_SRLV:         begin sh_var = 1'b1; alu = ALU_SRL; end
                    FN_SRAV:         begin sh_var = 1'b1; alu = ALU_SRA; end
                    FN_JR:           begin is_jr = 1'b1;  alu = ALU_JR;  end
                    default:         legal = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                is_br = 1'b1;
                sext  = 1'b1;
                alu   = (rt == RT_BLTZ) ? ALU_BLTZ : ALU_BGEZ;
                legal = (rt == RT_BLTZ) || (rt == RT_BGEZ);
            end
            OP_J:               is_j = 1'b1;
            OP_BEQ:             begin is_br = 1'b1; sext = 1'b1; alu = ALU_BEQ;  end
            OP_BNE:             begin is_br = 1'b1; sext = 1'b1; alu = ALU_BNE;  end
            OP_BLEZ:            begin is_br = 1'b1; sext = 1'b1; alu = ALU_BLEZ; end
            OP_BGTZ:            begin is_br = 1'b1; sext = 1'b1; alu = ALU_BGTZ; end
            OP_ADDI, OP_ADDIU:  begin i_alu = 1'b1; sext = 1'b1; alu = ALU_ADD;  end
            OP_SLTI:            begin i_alu = 1'b1; sext = 1'b1; alu = ALU_SLT;  end
            OP_SLTIU:           begin i_alu = 1'b1; sext = 1'b1; alu = ALU_SLTU; end
            OP_ANDI:            begin i_alu = 1'b1; zext = 1'b1; alu = ALU_ANDI; end
            OP_ORI:             begin i_alu = 1'b1; zext = 1'b1; alu = ALU_ORI;  end
            OP_XORI:            begin i_alu = 1'b1; zext = 1'b1; alu = ALU_XORI; end
            OP_LW:              begin is_lw = 1'b1; sext = 1'b1; end
            OP_SW:              begin is_sw = 1'b1; sext = 1'b1; end
            default:            legal = 1'b0;
        endcase
    end

    // The all-zero word would otherwise decode as SLL $0,$0,0; it is a pure NOP.
    assign nop  = (instr == 32'd0);
    assign kill = nop || !legal;

    assign ctrl = '{
        memtoreg: !kill && is_lw,
        regwrite: !kill && (is_lw || r_alu || sh_imm || sh_var || i_alu),
        memwrite: !kill && is_sw,
        memread:  !kill && is_lw,
        alusrca:  !kill && sh_imm,
        alusrcb:  !kill && (i_alu || is_lw || is_sw),
        regdst:   !kill && (r_alu || sh_imm || sh_var),
        j:        !kill && is_j,
        jr:       !kill && is_jr,
        illegal:  !legal
    };

    assign alucode = kill ? ALU_ADD : alu;
    assign imm     = kill ? '0
                   : sext ? {{(XLEN-16){instr[15]}}, instr[15:0]}
                   : zext ? {{(XLEN-16){1'b0}}, instr[15:0]}
                   : '0;

    assign uses_rs = !(nop || sh_imm || is_j);
    assign uses_rt = ((op == OP_R) && !nop) || is_sw || (op == OP_BEQ) || (op == OP_BNE);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered MIPS-I decode with valid/ready, load-use bubble, flush and ID/EX register
//   clk, reset (async, active-high); fetch side: if_valid, if_instr, if_pc, id_ready;
//   flush from EX; ex: decode_stage_if master carrying the ID/EX register and ex ready.
//   Optional DECODE_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt outputs.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    decode_stage_if.master  ex
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);
    if (XLEN < 32 || PERF_W < 1) begin : g_param_check
        $error("decode_stage: XLEN must be >= 32 and PERF_W >= 1");
    end

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] jtarget;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        alu_t            alucode;
        ctrl_t           ctrl;
    } idex_t;

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t          state;
    idex_t           r;
    idex_t           d;
    ctrl_t           ctrl;
    alu_t            alucode;
    logic [XLEN-1:0] imm;
    logic            uses_rs, uses_rt, advance, hazard, stall, take;

    decode_ctrl #(.XLEN(XLEN)) u_ctrl (
        .instr   (if_instr),
        .ctrl    (ctrl),
        .alucode (alucode),
        .imm     (imm),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt)
    );

    assign advance  = !r.valid || ex.ready;
    assign hazard   = if_valid && r.valid && r.ctrl.memread && (r.rt != 5'd0) &&
                      ((uses_rs && if_instr[25:21] == r.rt) || (uses_rt && if_instr[20:16] == r.rt));
    assign stall    = hazard && (state == RUN) && !flush;
    assign id_ready = advance && !stall;
    assign take     = if_valid && !flush && !stall;

    // (pc+4)[XLEN-1:28] only differs from pc[XLEN-1:28] when pc[27:2] is all ones.
    always_comb
        d = take ? '{
            valid:   1'b1,
            pc:      if_pc,
            imm:     imm,
            jtarget: {if_pc[XLEN-1:28] + (XLEN-28)'(&if_pc[27:2]), if_instr[25:0], 2'b00},
            rs:      if_instr[25:21],
            rt:      if_instr[20:16],
            rd:      if_instr[15:11],
            shamt:   if_instr[10:6],
            alucode: alucode,
            ctrl:    ctrl
        } : '0;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= RUN;
            r     <= '0;
        end else begin
            if (advance) r <= d;
            state <= flush ? RUN : !advance ? state : stall ? BUBBLE : RUN;
        end

`ifdef DECODE_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(stall && advance);
            perf_flush_cnt <= perf_flush_cnt + PERF_W'(flush && if_valid);
        end
`endif

    assign ex.valid    = r.valid;
    assign ex.pc       = r.pc;
    assign ex.rs       = r.rs;
    assign ex.rt       = r.rt;
    assign ex.rd       = r.rd;
    assign ex.shamt    = r.shamt;
    assign ex.imm      = r.imm;
    assign ex.jtarget  = r.jtarget;
    assign ex.alucode  = r.alucode;
    assign ex.memtoreg = r.ctrl.memtoreg;
    assign ex.regwrite = r.ctrl.regwrite;
    assign ex.memwrite = r.ctrl.memwrite;
    assign ex.memread  = r.ctrl.memread;
    assign ex.alusrca  = r.ctrl.alusrca;
    assign ex.alusrcb  = r.ctrl.alusrcb;
    assign ex.regdst   = r.ctrl.regdst;
    assign ex.j        = r.ctrl.j;
    assign ex.jr       = r.ctrl.jr;
    assign ex.illegal  = r.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage
module tb_decode_stage;
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [4:0]  alu;
        logic [9:0]  c;
        logic [31:0] imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        flush;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t cur;
    bit   acc = 1'b0;

    decode_stage_if #(.XLEN(32)) ex ();

    decode_stage #(.XLEN(32), .PERF_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .id_ready (id_ready),
        .flush    (flush),
        .ex       (ex)
`ifdef DECODE_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk)
        if (!reset && if_valid && id_ready && !flush) begin
            q.push_back(cur);
            acc <= 1'b1;
        end else
            acc <= 1'b0;

    always @(negedge clk)
        if (acc) begin
            if (q.size() == 0)
                chk("sb_underflow", 1, 0);
            else begin
                exp_t        e;
                logic [31:0] p4;
                e  = q.pop_front();
                p4 = e.pc + 32'd4;
                chk("valid", ex.valid, 1'b1);
                chk("pc", ex.pc, e.pc);
                chk("rs", ex.rs, e.ins[25:21]);
                chk("rt", ex.rt, e.ins[20:16]);
                chk("rd", ex.rd, e.ins[15:11]);
                chk("shamt", ex.shamt, e.ins[10:6]);
                chk("imm", ex.imm, e.imm);
                chk("jtarget", ex.jtarget, {p4[31:28], e.ins[25:0], 2'b00});
                chk("alucode", ex.alucode, e.alu);
                chk("ctrl", {ex.memtoreg, ex.regwrite, ex.memwrite, ex.memread, ex.alusrca,
                             ex.alusrcb, ex.regdst, ex.j, ex.jr, ex.illegal}, e.c);
            end
        end

    task automatic put(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] alu,
                       input logic [9:0] c, input logic [31:0] imm);
        cur      = '{ins: ins, pc: pc, alu: alu, c: c, imm: imm};
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] alu,
                         input logic [9:0] c, input logic [31:0] imm);
        int n = 0;
        put(ins, pc, alu, c, imm);
        @(negedge clk);
        while (!id_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) chk("issue_timeout", 0, 1);
        step();
        if_valid = 1'b0;
    endtask

    // ctrl order: memtoreg regwrite memwrite memread alusrca alusrcb regdst j jr illegal
    localparam logic [9:0] C_IALU = 10'b0100010000;
    localparam logic [9:0] C_RALU = 10'b0100001000;
    localparam logic [9:0] C_LW   = 10'b1101010000;
    localparam logic [9:0] C_SW   = 10'b0010010000;
    localparam logic [9:0] C_SHI  = 10'b0100101000;
    localparam logic [9:0] C_J    = 10'b0000000100;
    localparam logic [9:0] C_JR   = 10'b0000000010;
    localparam logic [9:0] C_ILL  = 10'b0000000001;
    localparam logic [9:0] C_NONE = 10'b0000000000;

    initial begin
        reset = 1'b1;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc = '0;
        flush = 1'b0;
        ex.ready = 1'b1;
        #3;
        chk("rst_ex_valid", ex.valid, 0);
        chk("rst_ex_pc", ex.pc, 0);
        chk("rst_alucode", ex.alucode, 0);
        chk("rst_regwrite", ex.regwrite, 0);
        chk("rst_id_ready", id_ready, 1);
`ifdef DECODE_PERF_CNT_EN
        chk("rst_stall_cnt", perf_stall_cnt, 0);
        chk("rst_flush_cnt", perf_flush_cnt, 0);
`endif
        step();
        reset = 1'b0;

        issue(32'h2001FFFB, 32'h100, 5'd0,  C_IALU, 32'hFFFFFFFB);
        issue(32'h34048000, 32'h104, 5'd8,  C_IALU, 32'h00008000);
        issue(32'h3801FFFF, 32'h108, 5'd7,  C_IALU, 32'h0000FFFF);
        issue(32'h2C41FFFF, 32'h10C, 5'd20, C_IALU, 32'hFFFFFFFF);
        issue(32'hFC000000, 32'h110, 5'd0,  C_ILL,  32'h0);
        issue(32'h00000001, 32'h114, 5'd0,  C_ILL,  32'h0);
        issue(32'h04220000, 32'h118, 5'd0,  C_ILL,  32'h0);
        issue(32'h0420FFFF, 32'h11C, 5'd15, C_NONE, 32'hFFFFFFFF);
        issue(32'h10228000, 32'h120, 5'd10, C_NONE, 32'hFFFF8000);
        issue(32'h00000000, 32'h124, 5'd0,  C_NONE, 32'h0);
        issue(32'h00021900, 32'h128, 5'd16, C_SHI,  32'h0);
        issue(32'h00221807, 32'h12C, 5'd18, C_RALU, 32'h0);
        issue(32'h03E00008, 32'h130, 5'd9,  C_JR,   32'h0);
        issue(32'h00223025, 32'h134, 5'd3,  C_RALU, 32'h0);
        issue(32'h08000010, 32'h1FFFFFFC, 5'd0, C_J, 32'h0);

        put(32'h8C220000, 32'h200, 5'd0, C_LW, 32'h0);
        step();
        put(32'h00421820, 32'h204, 5'd0, C_RALU, 32'h0);
        @(negedge clk);
        chk("hz_id_ready", id_ready, 0);
        @(negedge clk);
        chk("bubble_valid", ex.valid, 0);
        chk("bubble_id_ready", id_ready, 1);
        step();
        if_valid = 1'b0;
        @(negedge clk);
`ifdef DECODE_PERF_CNT_EN
        chk("stall_cnt_1", perf_stall_cnt, 1);
`endif

        put(32'h8C200000, 32'h300, 5'd0, C_LW, 32'h0);
        step();
        put(32'h00001820, 32'h304, 5'd0, C_RALU, 32'h0);
        @(negedge clk);
        chk("rt0_no_hz", id_ready, 1);
        step();
        if_valid = 1'b0;

        put(32'hAC250004, 32'h400, 5'd0, C_SW, 32'h4);
        step();
        ex.ready = 1'b0;
        put(32'h00223025, 32'h404, 5'd3, C_RALU, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_pc", ex.pc, 32'h400);
            chk("hold_valid", ex.valid, 1);
            chk("hold_memwrite", ex.memwrite, 1);
            chk("hold_imm", ex.imm, 32'h4);
            chk("hold_id_ready", id_ready, 0);
        end
        ex.ready = 1'b1;
        step();
        if_valid = 1'b0;

        put(32'h8C220000, 32'h500, 5'd0, C_LW, 32'h0);
        step();
        put(32'h00421820, 32'h504, 5'd0, C_RALU, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_id_ready", id_ready, 1);
        step();
        flush = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);
        chk("flush_dropped", ex.valid, 0);

        put(32'h8C220000, 32'h600, 5'd0, C_LW, 32'h0);
        step();
        put(32'h00421820, 32'h604, 5'd0, C_RALU, 32'h0);
        @(negedge clk);
        chk("run_after_flush", id_ready, 0);
        step();
        step();
        if_valid = 1'b0;
        @(negedge clk);
`ifdef DECODE_PERF_CNT_EN
        chk("stall_cnt_2", perf_stall_cnt, 2);
        chk("flush_cnt_1", perf_flush_cnt, 1);
`endif

        put(32'h8C220000, 32'h700, 5'd0, C_LW, 32'h0);
        step();
        put(32'h00421820, 32'h704, 5'd0, C_RALU, 32'h0);
        @(negedge clk);
        chk("pre_rst_stall", id_ready, 0);
        #2;
        reset = 1'b1;
        if_valid = 1'b0;
        #1;
        chk("midrst_valid", ex.valid, 0);
        chk("midrst_id_ready", id_ready, 1);
`ifdef DECODE_PERF_CNT_EN
        chk("midrst_stall_cnt", perf_stall_cnt, 0);
`endif
        step();
        reset = 1'b0;
        put(32'h00421820, 32'h704, 5'd0, C_RALU, 32'h0);
        @(negedge clk);
        chk("post_rst_ready", id_ready, 1);
        step();
        if_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered MIPS-I decode stage: decodes the fetched instruction into ALU code and control bits and holds them in the ID/EX pipeline register. Adds valid/ready flow control, load-use interlock (one-cycle bubble), branch/jump flush, immediate extension and illegal-opcode flagging. Sits between fetch and the execute stage; replaces the purely combinational decoder in the pipelined core.

## Interface
- XLEN, 32: datapath/PC width; must be ≥ 32.
- PERF_W, 32: performance counter width; used only with DECODE_PERF_CNT_EN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  PC of if_instr.
- id_ready  out  1  decode consumes if_instr this cycle.
- flush  in  1  taken branch/jump from EX; kill the instruction in decode.
- ex_ready  in  1  EX accepts the ID/EX register contents.
- ex_valid  out  1  ID/EX holds a live instruction.
- ex_pc  out  XLEN  registered PC.
- ex_rs, ex_rt, ex_rd, ex_shamt  out  5 each  register fields.
- ex_imm  out  XLEN  extended immediate.
- ex_jtarget  out  XLEN  {(pc+4)[XLEN-1:28], instr[25:0], 2'b00}.
- ex_alucode  out  5  ALU operation.
- ex_memtoreg, ex_regwrite, ex_memwrite, ex_memread, ex_alusrca, ex_alusrcb, ex_regdst, ex_j, ex_jr, ex_illegal  out  1 each  control bits.
- perf_stall_cnt, perf_flush_cnt  out  PERF_W  (DECODE_PERF_CNT_EN only).

## Operation
- Decoded ops: R-type ADD ADDU SUB SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV JR; I-type ADDI ADDIU ANDI ORI XORI SLTI SLTIU; LW SW; BEQ BNE BGEZ BGTZ BLEZ BLTZ; J.
- ALU codes: add 0, and 1, xor 2, or 3, nor 4, sub 5, andi 6, xori 7, ori 8, jr 9, beq 10, bne 11, bgez 12, bgtz 13, blez 14, bltz 15, sll 16, srl 17, sra 18, slt 19, sltu 20. BLTZ is decoded (code 15). SLLV/SRLV/SRAV map to sll/srl/sra with alusrca=0.
- Controls: regwrite = LW | R-ALU | shifts | I-ALU; regdst = R-ALU | shifts; alusrca = SLL/SRL/SRA only; alusrcb = I-ALU | LW | SW; memread = memtoreg = LW; memwrite = SW.
- Immediate: sign-extend for ADDI ADDIU SLTI SLTIU LW SW branches; zero-extend for ANDI ORI XORI; 0 otherwise.
- All-zero word: NOP, ex_valid=1, all enables 0, alucode 0.
- Unrecognised op/funct: ex_illegal=1, all enables 0, alucode 0.
- Advance = !ex_valid | ex_ready. ID/EX loads only when advance.
- Source use: uses_rs for all except SLL/SRL/SRA, J, NOP; uses_rt for R-type, SW, BEQ, BNE.
- Hazard = ex_valid & ex_memread & ex_rt≠0 & ((uses_rs & rs==ex_rt) | (uses_rt & rt==ex_rt)) & if_valid.
- FSM RUN/BUBBLE. RUN: hazard & advance & !flush → load bubble (ex_valid=0), id_ready=0, go BUBBLE. BUBBLE: no hazard check; behaves as RUN for the held instruction, returns to RUN on next advance.
- id_ready = advance & !(hazard & state==RUN & !flush).
- Flush: id_ready=1 (instruction dropped), ID/EX loads bubble when advance, state→RUN. Flush overrides hazard.

## Timing
- Latency 1 cycle: instruction accepted at edge N appears on ex_* after edge N.
- Reset (async): all outputs 0, state RUN, counters 0; id_ready follows combinational rules (1 after reset).
- ex_ready=0 with ex_valid=1: ex_* hold stable, id_ready=0.
- Bubble lasts exactly one cycle per load-use pair; if_instr must stay stable while id_ready=0.
- Reset mid-stall: FSM returns to RUN, pending bubble discarded.

## Configuration
- DECODE_PERF_CNT_EN defined: perf_stall_cnt increments each cycle a hazard bubble is inserted; perf_flush_cnt increments each cycle flush & if_valid; both wrap at 2^PERF_W.
- Undefined: counter ports and logic absent.

## Structure
- Package decode_pkg: opcode/funct/rt constants, ALU code enum, ctrl_t struct of control bits.
- Sub-module decode_ctrl: combinational instruction → ctrl_t, alucode, immediate, uses_rs/uses_rt, illegal.

## Test plan
- ADDI $1,$0,-5 (0x2001FFFB), ex_ready=1 → next cycle ex_valid=1, alucode 0, ex_imm 0xFFFFFFFB, regwrite=1, alusrcb=1.
- LW $2,0($1) then ADD $3,$2,$2 → one cycle with id_ready=0 and ex_valid=0 bubble, ADD issues next; perf_stall_cnt=1.
- LW $0,0($1) then ADD $3,$0,$0 → no bubble.
- ORI $4,$0,0x8000 → ex_imm 0x00008000, alucode 8.
- ex_ready=0 for 3 cycles with valid SW in ID/EX → ex_* stable, id_ready=0; flush during hazard → no bubble, instruction dropped, state RUN.
- Op 0x3F → ex_illegal=1, all enables 0; BLTZ (rt=0, op=1) → alucode 15.
